// File: rtl/cas_pkg.sv
// Shared cassette FSK definitions: decoder states, nominal periods in Q ticks,
// and the byte-emit record passed from the decoder FSM to its output register.
package cas_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HUNT = 2'd1,
    SYNC = 2'd2
  } cas_dec_state_t;

  localparam int CAS_CNT_W    = 10;
  localparam int CAS_MIN_PER  = 200;
  localparam int CAS_THRESH   = 560;
  localparam int CAS_MAX_PER  = 1000;
  localparam int CAS_PER_ONE  = 373;   // 2400 Hz at the Q rate
  localparam int CAS_PER_ZERO = 746;   // 1200 Hz at the Q rate

  localparam logic [7:0] CAS_SYNC_BYTE = 8'h55;

  typedef struct packed {
    logic       vld;
    logic [7:0] data;
  } cas_emit_t;

endpackage

// File: rtl/cas_period_meter.sv
// Synchronizes cas_in, detects rising edges and measures the Q-tick period
// between accepted edges. Short (glitch) edges leave the running count intact.
module cas_period_meter
  import cas_pkg::*;
#(
  parameter int MIN_PER = CAS_MIN_PER,
  parameter int MAX_PER = CAS_MAX_PER,
  parameter int CNT_W   = CAS_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             Q,
  input  logic             clr,
  input  logic             restart,
  input  logic             cas_in,
  output logic             edge_valid,
  output logic [CNT_W-1:0] per,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_PER);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_PER);

  logic [1:0]       sync;
  logic             sync_d;
  logic [CNT_W-1:0] cnt;
  logic             first;
  logic             rise;

  assign rise    = sync[1] & ~sync_d;
  assign timeout = (cnt > MAX_C);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync       <= '0;
      sync_d     <= 1'b0;
      cnt        <= '0;
      first      <= 1'b1;
      per        <= '0;
      edge_valid <= 1'b0;
    end else begin
      sync       <= {sync[0], cas_in};
      sync_d     <= sync[1];
      edge_valid <= 1'b0;
      if (clr) begin
        cnt   <= '0;
        first <= 1'b1;
      end else begin
        // The first edge of a run only starts timing; it has no period of its own.
        if (rise && (first || cnt >= MIN_C)) begin
          cnt        <= '0;
          per        <= cnt;
          edge_valid <= ~first;
          first      <= 1'b0;
        end else if (Q && cnt != '1) begin
          cnt <= cnt + 1'b1;
        end
        if (restart) first <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cas_fsk_decoder.sv
// Cassette record path: turns measured FSK periods into bits, aligns on the
// leader byte and hands decoded bytes to the SDRAM writer over valid/ready.
module cas_fsk_decoder
  import cas_pkg::*;
#(
  parameter int         MIN_PER   = CAS_MIN_PER,
  parameter int         THRESH    = CAS_THRESH,
  parameter int         MAX_PER   = CAS_MAX_PER,
  parameter int         CNT_W     = CAS_CNT_W,
  parameter logic [7:0] SYNC_BYTE = CAS_SYNC_BYTE
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        Q,
  input  logic        en,
  input  logic        cas_in,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        synced,
  output logic        gap,
  output logic        overrun,
  output logic [15:0] byte_count
);

  localparam logic [CNT_W-1:0] THR_C = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_PER);

  cas_dec_state_t   state, state_nxt;
  logic [7:0]       sr, sr_nxt, sr_sh;
  logic [2:0]       bcnt, bcnt_nxt;
  cas_emit_t        emit;
  logic             gap_nxt;
  logic             restart;
  logic             edge_valid;
  logic [CNT_W-1:0] per;
  logic             timeout;
  logic             bit_ok, bit_one, is_gap;

  cas_period_meter #(
    .MIN_PER (MIN_PER),
    .MAX_PER (MAX_PER),
    .CNT_W   (CNT_W)
  ) u_meter (
    .clk        (clk),
    .reset_n    (reset_n),
    .Q          (Q),
    .clr        (state == IDLE),
    .restart    (restart),
    .cas_in     (cas_in),
    .edge_valid (edge_valid),
    .per        (per),
    .timeout    (timeout)
  );

  assign bit_ok  = edge_valid && (per <= MAX_C);
  assign bit_one = (per < THR_C);
  assign is_gap  = (edge_valid && (per > MAX_C)) || timeout;
  assign sr_sh   = {bit_one, sr[7:1]};
  assign synced  = (state == SYNC);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    bcnt_nxt  = bcnt;
    emit      = '0;
    gap_nxt   = 1'b0;
    restart   = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_nxt = HUNT;
          sr_nxt    = '0;
          bcnt_nxt  = '0;
        end
      end
      HUNT: begin
        if (bit_ok) begin
          sr_nxt = sr_sh;
          if (sr_sh == SYNC_BYTE) begin
            state_nxt = SYNC;
            bcnt_nxt  = '0;
            emit.vld  = 1'b1;
            emit.data = sr_sh;
          end
        end
      end
      SYNC: begin
        // Alignment is reached mid-stream, so only a lost carrier re-arms the meter.
        if (is_gap) begin
          state_nxt = HUNT;
          gap_nxt   = 1'b1;
          restart   = 1'b1;
          sr_nxt    = '0;
          bcnt_nxt  = '0;
        end else if (bit_ok) begin
          sr_nxt   = sr_sh;
          bcnt_nxt = bcnt + 3'd1;
          if (bcnt == 3'd7) begin
            emit.vld  = 1'b1;
            emit.data = sr_sh;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!en) begin
      state_nxt = IDLE;
      emit      = '0;
      gap_nxt   = 1'b0;
      restart   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr         <= '0;
      bcnt       <= '0;
      gap        <= 1'b0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      overrun    <= 1'b0;
      byte_count <= '0;
    end else begin
      sr   <= sr_nxt;
      bcnt <= bcnt_nxt;
      gap  <= gap_nxt;
      if (emit.vld) begin
        if (!byte_valid || byte_ready) begin
          byte_data  <= emit.data;
          byte_valid <= 1'b1;
          byte_count <= byte_count + 16'd1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (byte_valid && byte_ready) begin
        byte_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cas_fsk_decoder.sv
// Drives FSK waveforms (scaled periods) into cas_fsk_decoder and checks the
// byte stream against a bit-window reference model.
module tb_cas_fsk_decoder;

  localparam int MINP = 20;
  localparam int THR  = 56;
  localparam int MAXP = 100;
  localparam int CW   = 7;

  logic        clk;
  logic        reset_n = 1'b0;
  logic        Q = 1'b0;
  logic        en = 1'b0;
  logic        cas_in = 1'b0;
  logic        byte_ready = 1'b0;
  logic [7:0]  byte_data;
  logic        byte_valid, synced, gap, overrun;
  logic [15:0] byte_count;

  int tests = 0;
  int fails = 0;

  cas_fsk_decoder #(
    .MIN_PER(MINP), .THRESH(THR), .MAX_PER(MAXP), .CNT_W(CW), .SYNC_BYTE(8'h55)
  ) dut (
    .clk(clk), .reset_n(reset_n), .Q(Q), .en(en), .cas_in(cas_in),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .synced(synced), .gap(gap), .overrun(overrun), .byte_count(byte_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Irregular Q strobe: roughly three ticks per four clocks.
  initial forever begin
    @(negedge clk);
    Q = ($urandom_range(0, 3) != 0);
  end

  logic [7:0] rx_q[$];
  logic       rx_sync[$];
  int         gap_pulses = 0, gap_cycles = 0, unstable = 0;
  logic       gap_d = 1'b0, hold_d = 1'b0;
  logic [7:0] data_d = 8'h00;

  always @(negedge clk) begin
    if (!reset_n) begin
      hold_d = 1'b0;
      gap_d  = 1'b0;
    end else begin
      if (byte_valid && byte_ready) begin
        rx_q.push_back(byte_data);
        rx_sync.push_back(synced);
      end
      if (hold_d && byte_data !== data_d) unstable++;
      hold_d = byte_valid && !byte_ready;
      data_d = byte_data;
      if (gap) gap_cycles++;
      if (gap && !gap_d) gap_pulses++;
      gap_d = gap;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge clk);
      if (Q) k++;
    end
    #1;
  endtask

  bit         mbits[$];
  logic [7:0] exp_q[$];

  task automatic load_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) mbits.push_back(b[i]);
  endtask

  // One cycle per bit, rising edge first; a bit is only measured once the next edge arrives.
  task automatic send_wave(input bit jitter, input bit glitch, input bit trailer);
    foreach (mbits[i]) begin
      int p;
      int h;
      p = mbits[i] ? 37 : 75;
      if (jitter) p += mbits[i] ? int'($urandom_range(0, 10)) - 5 : int'($urandom_range(0, 16)) - 8;
      h = p / 2;
      cas_in = 1'b1;
      if (glitch && $urandom_range(0, 1) == 1) begin
        ticks(3); cas_in = 1'b0; ticks(2); cas_in = 1'b1; ticks(h - 5);
      end else begin
        ticks(h);
      end
      cas_in = 1'b0;
      ticks(p - h);
    end
    if (trailer) begin
      cas_in = 1'b1; ticks(18);
      cas_in = 1'b0; ticks(150);
    end
  endtask

  // Hunt: the last 8 bits (zeros before the burst) read LSB-first equal 0x55.
  // Then every further group of 8 bits is one byte. Returns 1 if aligned at the end.
  function automatic bit model(input int nbits);
    bit al = 1'b0;
    int n  = 0;
    for (int i = 0; i < nbits; i++) begin
      if (!al) begin
        int v = 0;
        for (int j = 0; j < 8; j++)
          if (i - 7 + j >= 0) v += int'(mbits[i - 7 + j]) << j;
        if (v == 'h55) begin
          al = 1'b1;
          n  = 0;
          exp_q.push_back(8'h55);
        end
      end else begin
        n++;
        if (n == 8) begin
          int v = 0;
          for (int j = 0; j < 8; j++) v += int'(mbits[i - 7 + j]) << j;
          exp_q.push_back(8'(v));
          n = 0;
        end
      end
    end
    return al;
  endfunction

  task automatic new_burst();
    mbits.delete();
    exp_q.delete();
    rx_q.delete();
    rx_sync.delete();
  endtask

  task automatic cmp_rx(input string tag);
    check({tag, "_n"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check($sformatf("%s_b%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    int  cnt_total;
    int  g0;
    bit  al;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(byte_valid), 0);
    check("rst_data", 32'(byte_data), 0);
    check("rst_synced", 32'(synced), 0);
    check("rst_gap", 32'(gap), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_count", 32'(byte_count), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Clean leader 16x55, 3C, A5
    byte_ready = 1'b1;
    en = 1'b1;
    ticks(5);
    new_burst();
    repeat (16) load_byte(8'h55);
    load_byte(8'h3C);
    load_byte(8'hA5);
    al = model(mbits.size());
    g0 = gap_pulses;
    send_wave(1'b0, 1'b0, 1'b1);
    cmp_rx("clean");
    check("clean_sync_first", 32'(rx_sync.size() > 0 ? rx_sync[0] : 1'b0), 1);
    check("clean_count", 32'(byte_count), 18);
    check("clean_gap", gap_pulses - g0, 32'(al));
    check("clean_unsynced", 32'(synced), 0);
    cnt_total = 18;

    // Jittered periods with glitch edges
    new_burst();
    repeat (4) load_byte(8'h55);
    repeat (6) load_byte(8'($urandom_range(0, 255)));
    al = model(mbits.size());
    g0 = gap_pulses;
    send_wave(1'b1, 1'b1, 1'b1);
    cmp_rx("jit");
    cnt_total += exp_q.size();
    check("jit_count", 32'(byte_count), 32'(cnt_total));
    check("jit_gap", gap_pulses - g0, 32'(al));

    // en dropped mid-byte, then a fresh leader
    new_burst();
    repeat (3) load_byte(8'h55);
    repeat (4) mbits.push_back(1'b1);
    void'(model(mbits.size() - 1));
    g0 = gap_pulses;
    send_wave(1'b0, 1'b0, 1'b0);
    check("endrop_synced_before", 32'(synced), 1);
    en = 1'b0;
    ticks(20);
    check("endrop_synced", 32'(synced), 0);
    check("endrop_nogap", gap_pulses - g0, 0);
    cmp_rx("endrop");
    cnt_total += exp_q.size();
    en = 1'b1;
    ticks(5);
    new_burst();
    repeat (3) load_byte(8'h55);
    load_byte(8'hA5);
    void'(model(mbits.size()));
    send_wave(1'b1, 1'b0, 1'b1);
    cmp_rx("resume");
    cnt_total += exp_q.size();
    check("resume_count", 32'(byte_count), 32'(cnt_total));

    // Asynchronous reset mid-byte while a byte is pending
    byte_ready = 1'b0;
    new_burst();
    repeat (2) load_byte(8'h55);
    mbits.push_back(1'b1);
    mbits.push_back(1'b0);
    mbits.push_back(1'b1);
    send_wave(1'b0, 1'b0, 1'b0);
    check("pre_rst_valid", 32'(byte_valid), 1);
    check("pre_rst_overrun", 32'(overrun), 1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_valid", 32'(byte_valid), 0);
    check("arst_data", 32'(byte_data), 0);
    check("arst_synced", 32'(synced), 0);
    check("arst_gap", 32'(gap), 0);
    check("arst_overrun", 32'(overrun), 0);
    check("arst_count", 32'(byte_count), 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    ticks(5);

    // Backpressure: second byte dropped, first held
    new_burst();
    load_byte(8'h55);
    load_byte(8'h3C);
    send_wave(1'b0, 1'b0, 1'b1);
    check("ovr_nohs", rx_q.size(), 0);
    check("ovr_valid", 32'(byte_valid), 1);
    check("ovr_data", 32'(byte_data), 32'h55);
    check("ovr_flag", 32'(overrun), 1);
    check("ovr_count", 32'(byte_count), 1);
    byte_ready = 1'b1;
    @(posedge clk);
    #1;
    byte_ready = 1'b0;
    check("ovr_drained", 32'(byte_valid), 0);
    check("ovr_rx_n", rx_q.size(), 1);
    check("ovr_rx_b0", 32'(rx_q.size() > 0 ? rx_q[0] : 8'h00), 32'h55);
    check("ovr_sticky", 32'(overrun), 1);

    check("hold_stable", unstable, 0);
    check("gap_one_cycle", gap_cycles, gap_pulses);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
